// File: rtl/store_merge_unit.sv
// Store path from the datapath to a word-only data memory: sb/sh use read-modify-write, sw writes directly.
// Optional feature macro: MISALIGN_TRAP_EN, which traps misaligned half/word stores instead of forcing alignment.
module store_merge_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  output logic              done,
  output logic              misaligned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        lane_q;
  logic              byte_q;
  logic [15:0]       data_q;
  logic [31:0]       buf_q;
  logic [31:0]       merged;
  logic              accept;
  logic              is_word;
  logic              mis_req;
  logic [1:0]        lane;

  assign accept  = req_valid && (state_q == IDLE);
  assign is_word = req_size[1];

  // Halfwords only look at addr[1] and words at no low bits, so a misaligned
  // request without the trap lands on the naturally aligned lane.
  always_comb begin
    lane = 2'b00;
    if (req_size == 2'b00)      lane = req_addr[1:0];
    else if (req_size == 2'b01) lane = {req_addr[1], 1'b0};
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_q;
  assign mis_req    = ((req_size == 2'b01) && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
  assign misaligned = (state_q == DONE) && mis_q;
`else
  assign mis_req    = 1'b0;
  assign misaligned = 1'b0;
`endif

  assign req_ready = (state_q == IDLE);
  assign mem_rd    = (state_q == READ);
  assign mem_wr    = (state_q == WRITE);
  assign done      = (state_q == DONE);
  assign mem_addr  = addr_q;
  assign mem_wdata = buf_q;

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the case/if can leave it unassigned and infer a latch.
  always_comb begin
    merged = mem_rdata;
    if (byte_q) merged[{lane_q, 3'b000} +: 8]        = data_q[7:0];
    else        merged[{lane_q[1], 4'b0000} +: 16]   = data_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (mis_req)      state_d = DONE;
          else if (is_word) state_d = WRITE;
          else              state_d = READ;
        end
      end
      READ:    if (mem_ack) state_d = WRITE;
      WRITE:   if (mem_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lane_q  <= 2'b00;
      byte_q  <= 1'b0;
      data_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
        lane_q <= lane;
        byte_q <= (req_size == 2'b00);
        data_q <= req_wdata[15:0];
        buf_q  <= req_wdata;
      end else if ((state_q == READ) && mem_ack) begin
        buf_q <= merged;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    mis_q <= 1'b0;
    else if (accept) mis_q <= mis_req;
  end
`endif

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: table of single stores against a small
// responding memory, plus wait-state and reset-abort sequences.
module tb_store_merge_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        done;
  logic        misaligned;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  store_merge_unit #(.ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .done(done), .misaligned(misaligned),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] rdata;
    int          exp_rd_n;
    int          exp_wr_n;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    int          exp_done_cyc;
    logic        exp_mis;
  } vec_t;

  // Issues one store, answers memory strobes after dly wait cycles, and
  // records what happened. Cycle 1 is the first cycle after the accept edge.
  task automatic do_store(input string tag, input vec_t v, input int dly);
    int          rd_n = 0, wr_n = 0, done_n = 0, done_cyc = -1, w = 0;
    logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0, acc_addr = '0;
    logic        stable = 1'b1, mis_seen = 1'b0, ready_low = 1'b1;
    @(negedge clk);
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_size  = v.size;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      mem_ack = 1'b0;
      if (mem_rd && mem_wr) stable = 1'b0;
      if (mem_rd || mem_wr) begin
        if (w == 0) acc_addr = mem_addr;
        else if (mem_addr !== acc_addr) stable = 1'b0;
        if (w == dly) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
          if (mem_rd) begin rd_n++; rd_addr = mem_addr; end
          else begin wr_n++; wr_addr = mem_addr; wr_data = mem_wdata; end
          w = 0;
        end else begin
          mem_rdata = $urandom;
          w++;
        end
      end
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
        if (misaligned) mis_seen = 1'b1;
        if (req_ready) ready_low = 1'b0;
      end
      if (done_cyc > 0 && cyc >= done_cyc + 2) break;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check({tag, "_rd_count"}, rd_n, v.exp_rd_n);
    check({tag, "_wr_count"}, wr_n, v.exp_wr_n);
    if (v.exp_rd_n > 0) check({tag, "_rd_addr"}, rd_addr, v.exp_addr);
    if (v.exp_wr_n > 0) begin
      check({tag, "_wr_addr"}, wr_addr, v.exp_addr);
      check({tag, "_wr_data"}, wr_data, v.exp_data);
    end
    check({tag, "_done_cycle"}, done_cyc, v.exp_done_cyc);
    check({tag, "_done_count"}, done_n, 32'd1);
    check({tag, "_misaligned"}, {31'b0, mis_seen}, {31'b0, v.exp_mis});
    check({tag, "_strobes_stable"}, {31'b0, stable}, 32'd1);
    check({tag, "_ready_low_in_done"}, {31'b0, ready_low}, 32'd1);
  endtask

  vec_t vecs[10];
  vec_t v;

  initial begin
    //            addr       wdata         sz     rdata        rd wr exp_addr     exp_data     dc mis
    vecs[0] = '{32'h100, 32'hDEADBEEF, 2'b10, 32'h0,        0, 1, 32'h100, 32'hDEADBEEF, 2, 1'b0};
    vecs[1] = '{32'h103, 32'h000000AA, 2'b00, 32'h11223344, 1, 1, 32'h100, 32'hAA223344, 3, 1'b0};
    vecs[2] = '{32'h102, 32'h1234BEEF, 2'b01, 32'h11223344, 1, 1, 32'h100, 32'hBEEF3344, 3, 1'b0};
    vecs[3] = '{32'h100, 32'h00000055, 2'b00, 32'h11223344, 1, 1, 32'h100, 32'h11223355, 3, 1'b0};
    vecs[4] = '{32'h101, 32'hFFFFFF77, 2'b00, 32'hAABBCCDD, 1, 1, 32'h100, 32'hAABB77DD, 3, 1'b0};
    vecs[5] = '{32'h1F6, 32'h00000066, 2'b00, 32'h00000000, 1, 1, 32'h1F4, 32'h00660000, 3, 1'b0};
    vecs[6] = '{32'h100, 32'h0000CAFE, 2'b01, 32'hFFFFFFFF, 1, 1, 32'h100, 32'hFFFFCAFE, 3, 1'b0};
    vecs[7] = '{32'h204, 32'h12345678, 2'b11, 32'h0,        0, 1, 32'h204, 32'h12345678, 2, 1'b0};
`ifdef MISALIGN_TRAP_EN
    vecs[8] = '{32'h101, 32'h0000ABCD, 2'b01, 32'h11223344, 0, 0, 32'h100, 32'h0,        1, 1'b1};
    vecs[9] = '{32'h106, 32'h87654321, 2'b10, 32'h0,        0, 0, 32'h104, 32'h0,        1, 1'b1};
`else
    vecs[8] = '{32'h101, 32'h0000ABCD, 2'b01, 32'h11223344, 1, 1, 32'h100, 32'h1122ABCD, 3, 1'b0};
    vecs[9] = '{32'h106, 32'h87654321, 2'b10, 32'h0,        0, 1, 32'h104, 32'h87654321, 2, 1'b0};
`endif

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_size  = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    #23;
    check("reset_ready",     {31'b0, req_ready},  32'd1);
    check("reset_strobes",   {30'b0, mem_rd, mem_wr}, 32'd0);
    check("reset_done_mis",  {30'b0, done, misaligned}, 32'd0);
    check("reset_mem_addr",  mem_addr,  32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) do_store($sformatf("vec%0d", i), vecs[i], 0);

    // Three wait cycles in both READ and WRITE: done lands 1 + 4 + 4 cycles after accept.
    v = '{32'h201, 32'h00000099, 2'b00, 32'h01020304, 1, 1, 32'h200, 32'h01029904, 9, 1'b0};
    do_store("sb_wait3", v, 3);

    // Reset while a word write is pending must drop mem_wr at once and never pulse done.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h300;
    req_wdata = 32'hCAFEF00D;
    req_size  = 2'b10;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_pre_wr", {31'b0, mem_wr}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_wr_drop",   {31'b0, mem_wr},    32'd0);
    check("rst_no_done",   {31'b0, done},      32'd0);
    check("rst_ready",     {31'b0, req_ready}, 32'd1);
    check("rst_addr_zero", mem_addr,           32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    begin
      logic quiet = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (done || mem_wr || mem_rd || !req_ready) quiet = 1'b0;
      end
      check("rst_quiet_after", {31'b0, quiet}, 32'd1);
    end
    v = '{32'h304, 32'h0BADF00D, 2'b10, 32'h0, 0, 1, 32'h304, 32'h0BADF00D, 2, 1'b0};
    do_store("sw_after_rst", v, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
